flash_page_buffer: RTL

FLASH_PAGE_BUFFER -- requirements
Module: flash_page_buffer

---
 rtl/flash_page_buffer_pkg.sv | 19 +
 rtl/flash_page_buffer_bufram.sv | 82 ++++++++
 rtl/flash_page_buffer.sv | 113 +++++++++++
 3 files changed

// File: rtl/flash_page_buffer_pkg.sv
// Shared types and defaults for the flash page buffer: bank owner encoding,
// default geometry and the per-byte parity function.
package flash_page_buffer_pkg;

    typedef enum logic {
        OWN_CPU   = 1'b0,
        OWN_FLASH = 1'b1
    } owner_t;

    localparam int DEF_DW    = 32;
    localparam int DEF_AW    = 10;
    localparam int DEF_NBANK = 2;

    // Even parity: the stored bit makes the byte plus parity bit have an even count of ones.
    function automatic logic byte_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/flash_page_buffer_bufram.sv
// True dual-port RAM: port a has byte enables, port b writes full words; both read-first.
// Optional per-byte parity storage and checking under FLASH_BUF_PARITY_EN.
module flash_bufram
    import flash_page_buffer_pkg::*;
#(
    parameter int DW    = DEF_DW,
    parameter int ABITS = DEF_AW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_we,
    input  logic [DW/8-1:0]   a_be,
    input  logic [ABITS-1:0]  a_addr,
    input  logic [DW-1:0]     a_wdata,
    output logic [DW-1:0]     a_rdata,
    input  logic              b_we,
    input  logic [ABITS-1:0]  b_addr,
    input  logic [DW-1:0]     b_wdata,
    output logic [DW-1:0]     b_rdata
`ifdef FLASH_BUF_PARITY_EN
    ,
    output logic              par_err
`endif
);

    localparam int NB    = DW / 8;
    localparam int DEPTH = 1 << ABITS;

    logic [DW-1:0] mem [DEPTH];

    // The owner check upstream guarantees both ports never write one word in the same cycle.
    always_ff @(posedge clk) begin
        if (b_we)
            mem[b_addr] <= b_wdata;
        for (int i = 0; i < NB; i++)
            if (a_we && a_be[i])
                mem[a_addr][i*8 +: 8] <= a_wdata[i*8 +: 8];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_rdata <= '0;
            b_rdata <= '0;
        end else begin
            a_rdata <= mem[a_addr];
            b_rdata <= mem[b_addr];
        end
    end

`ifdef FLASH_BUF_PARITY_EN
    logic [NB-1:0] par_mem [DEPTH];
    logic [NB-1:0] a_par_q;
    logic [NB-1:0] b_par_q;

    function automatic logic [NB-1:0] word_par(input logic [DW-1:0] w);
        word_par = '0;
        for (int i = 0; i < NB; i++)
            word_par[i] = byte_parity(w[i*8 +: 8]);
    endfunction

    always_ff @(posedge clk) begin
        if (b_we)
            par_mem[b_addr] <= word_par(b_wdata);
        for (int i = 0; i < NB; i++)
            if (a_we && a_be[i])
                par_mem[a_addr][i] <= byte_parity(a_wdata[i*8 +: 8]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_par_q <= '0;
            b_par_q <= '0;
        end else begin
            a_par_q <= par_mem[a_addr];
            b_par_q <= par_mem[b_addr];
        end
    end

    assign par_err = (|(a_par_q ^ word_par(a_rdata))) | (|(b_par_q ^ word_par(b_rdata)));
`endif

endmodule

// File: rtl/flash_page_buffer.sv
// Ping-pong page buffer between a CPU and a NAND flash engine with per-bank ownership.
// Define FLASH_BUF_PARITY_EN to add byte parity storage and the par_err output.
//
// state     | meaning
// OWN_CPU   | bank writable by the CPU port, waiting for cpu_bank_done
// OWN_FLASH | bank writable by the flash port, waiting for flash_bank_done
module flash_page_buffer
    import flash_page_buffer_pkg::*;
#(
    parameter int DW    = DEF_DW,
    parameter int AW    = DEF_AW,
    parameter int NBANK = DEF_NBANK
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_wr_en,
    input  logic [AW-1:0]     cpu_addr,
    input  logic [DW-1:0]     cpu_wdata,
    input  logic [DW/8-1:0]   cpu_be,
    output logic [DW-1:0]     cpu_rdata,
    input  logic              cpu_bank_done,
    output logic              cpu_bank_ready,
    input  logic              flash_wr_en,
    input  logic [AW-1:0]     flash_addr,
    input  logic [DW-1:0]     flash_wdata,
    output logic [DW-1:0]     flash_rdata,
    input  logic              flash_bank_done,
    output logic              flash_bank_ready,
    output logic              access_err
`ifdef FLASH_BUF_PARITY_EN
    ,
    output logic              par_err
`endif
);

    localparam int PW = (NBANK > 2) ? 2 : 1;

    owner_t        own_q [NBANK];
    owner_t        own_d [NBANK];
    logic [PW-1:0] cpu_ptr, cpu_ptr_d;
    logic [PW-1:0] flash_ptr, flash_ptr_d;
    logic          err_d;

    function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
        return (p == PW'(NBANK - 1)) ? '0 : p + 1'b1;
    endfunction

    assign cpu_bank_ready   = (own_q[cpu_ptr] == OWN_CPU);
    assign flash_bank_ready = (own_q[flash_ptr] == OWN_FLASH);

    // Ownership is judged before this cycle's handover, so a same-cycle collision favours the current owner.
    always_comb begin
        own_d       = own_q;
        cpu_ptr_d   = cpu_ptr;
        flash_ptr_d = flash_ptr;
        err_d       = 1'b0;
        if (cpu_bank_done) begin
            if (cpu_bank_ready) begin
                own_d[cpu_ptr] = OWN_FLASH;
                cpu_ptr_d      = inc_ptr(cpu_ptr);
            end else begin
                err_d = 1'b1;
            end
        end
        if (flash_bank_done) begin
            if (flash_bank_ready) begin
                own_d[flash_ptr] = OWN_CPU;
                flash_ptr_d      = inc_ptr(flash_ptr);
            end else begin
                err_d = 1'b1;
            end
        end
        if ((cpu_wr_en && !cpu_bank_ready) || (flash_wr_en && !flash_bank_ready))
            err_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NBANK; i++)
                own_q[i] <= OWN_CPU;
            cpu_ptr    <= '0;
            flash_ptr  <= '0;
            access_err <= 1'b0;
        end else begin
            own_q      <= own_d;
            cpu_ptr    <= cpu_ptr_d;
            flash_ptr  <= flash_ptr_d;
            access_err <= err_d;
        end
    end

    flash_bufram #(
        .DW    (DW),
        .ABITS (PW + AW)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .a_we    (cpu_wr_en && cpu_bank_ready),
        .a_be    (cpu_be),
        .a_addr  ({cpu_ptr, cpu_addr}),
        .a_wdata (cpu_wdata),
        .a_rdata (cpu_rdata),
        .b_we    (flash_wr_en && flash_bank_ready),
        .b_addr  ({flash_ptr, flash_addr}),
        .b_wdata (flash_wdata),
        .b_rdata (flash_rdata)
`ifdef FLASH_BUF_PARITY_EN
        ,
        .par_err (par_err)
`endif
    );

endmodule
